// File: rtl/fp_rf_pkg.sv
// Shared sizing and types for the FP register file and its scoreboard.
package fp_rf_pkg;

    localparam int FP_XLEN  = 32;
    localparam int FP_NREGS = 32;
    localparam int FP_AW    = 5;

    typedef logic [FP_AW-1:0]   fp_idx_t;
    typedef logic [FP_XLEN-1:0] fp_word_t;

endpackage

// File: rtl/fp_scoreboard.sv
// Pending-write scoreboard: one busy bit per FP register, RAW/WAW hazard
// detection and the issue stall.
// Optional macro FP_RF_BYPASS_EN: a same-cycle writeback releases a waiting
// dependent instruction instead of holding it one more cycle.
module fp_scoreboard
    import fp_rf_pkg::*;
#(
    parameter int NREGS = FP_NREGS,
    parameter int AW    = FP_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_fp_en,
    input  logic [AW-1:0]    wb_rd,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rs1,
    input  logic [AW-1:0]    issue_rs2,
    input  logic [AW-1:0]    issue_rs3,
    input  logic             issue_uses_rs3,
    input  logic             issue_fp_dest,
    input  logic [AW-1:0]    issue_rd,
    output logic             stall,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic clr1, clr2, clr3, clr_dst;
    logic haz1, haz2, haz3, haz_dst;
    logic accept;

    // Writeback-release terms; without bypass a dependent waits one extra cycle
    always_comb begin
        clr1    = 1'b0;
        clr2    = 1'b0;
        clr3    = 1'b0;
        clr_dst = 1'b0;
`ifdef FP_RF_BYPASS_EN
        clr1    = wb_fp_en && (wb_rd == issue_rs1);
        clr2    = wb_fp_en && (wb_rd == issue_rs2);
        clr3    = wb_fp_en && (wb_rd == issue_rs3);
        clr_dst = wb_fp_en && (wb_rd == issue_rd);
`endif
    end

    // Hazard detection and stall; the destination check allows one outstanding write per register
    always_comb begin
        haz1    = busy_q[issue_rs1] && !clr1;
        haz2    = busy_q[issue_rs2] && !clr2;
        haz3    = issue_uses_rs3 && busy_q[issue_rs3] && !clr3;
        haz_dst = issue_fp_dest && busy_q[issue_rd] && !clr_dst;
        stall   = issue_valid && (haz1 || haz2 || haz3 || haz_dst);
        accept  = issue_valid && !stall;
    end

    // Next busy state: clear first so that a same-index set from a new writer wins
    always_comb begin
        busy_d = busy_q;
        if (wb_fp_en)
            busy_d[wb_rd] = 1'b0;
        if (accept && issue_fp_dest)
            busy_d[issue_rd] = 1'b1;
    end

    // Busy register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/fp_regfile_sb.sv
// FP register file with three combinational read ports and a pending-write
// scoreboard that stalls issue on RAW/WAW hazards.
// Optional macro FP_RF_BYPASS_EN: write-through forwarding of the writeback
// data onto matching read ports, plus same-cycle hazard release.
module fp_regfile_sb
    import fp_rf_pkg::*;
#(
    parameter int XLEN  = FP_XLEN,
    parameter int NREGS = FP_NREGS,
    parameter int AW    = FP_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_fp_en,
    input  logic [AW-1:0]    wb_rd,
    input  logic [XLEN-1:0]  fp_wdata,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rs1,
    input  logic [AW-1:0]    issue_rs2,
    input  logic [AW-1:0]    issue_rs3,
    input  logic             issue_uses_rs3,
    input  logic             issue_fp_dest,
    input  logic [AW-1:0]    issue_rd,
    output logic [XLEN-1:0]  rdata1,
    output logic [XLEN-1:0]  rdata2,
    output logic [XLEN-1:0]  rdata3,
    output logic             stall,
    output logic [NREGS-1:0] busy_vec
);

    if (AW != $clog2(NREGS)) begin : g_bad_aw
        $error("AW must equal clog2(NREGS)");
    end

    logic [XLEN-1:0] regs_q [NREGS];

    // Register array; f0 is an ordinary register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else if (wb_fp_en) begin
            regs_q[wb_rd] <= fp_wdata;
        end
    end

    // Read ports, with write-through forwarding when bypass is built in
    always_comb begin
        rdata1 = regs_q[issue_rs1];
        rdata2 = regs_q[issue_rs2];
        rdata3 = regs_q[issue_rs3];
`ifdef FP_RF_BYPASS_EN
        if (wb_fp_en && (wb_rd == issue_rs1)) rdata1 = fp_wdata;
        if (wb_fp_en && (wb_rd == issue_rs2)) rdata2 = fp_wdata;
        if (wb_fp_en && (wb_rd == issue_rs3)) rdata3 = fp_wdata;
`endif
    end

    fp_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .wb_fp_en       (wb_fp_en),
        .wb_rd          (wb_rd),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_rs3      (issue_rs3),
        .issue_uses_rs3 (issue_uses_rs3),
        .issue_fp_dest  (issue_fp_dest),
        .issue_rd       (issue_rd),
        .stall          (stall),
        .busy_vec       (busy_vec)
    );

endmodule

// File: tb/tb_fp_regfile_sb.sv
// Self-checking bench for fp_regfile_sb: directed scenarios plus a randomized
// run against a register/busy-bit reference model.
module tb_fp_regfile_sb;

`ifdef FP_RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        wb_fp_en;
    logic [4:0]  wb_rd;
    logic [31:0] fp_wdata;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rs3;
    logic        issue_uses_rs3;
    logic        issue_fp_dest;
    logic [4:0]  issue_rd;
    logic [31:0] rdata1, rdata2, rdata3;
    logic        stall;
    logic [31:0] busy_vec;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    fp_regfile_sb dut (
        .clk            (clk),
        .rst            (rst),
        .wb_fp_en       (wb_fp_en),
        .wb_rd          (wb_rd),
        .fp_wdata       (fp_wdata),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_rs3      (issue_rs3),
        .issue_uses_rs3 (issue_uses_rs3),
        .issue_fp_dest  (issue_fp_dest),
        .issue_rd       (issue_rd),
        .rdata1         (rdata1),
        .rdata2         (rdata2),
        .rdata3         (rdata3),
        .stall          (stall),
        .busy_vec       (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit released(input logic [4:0] idx);
        return BYPASS && wb_fp_en && (wb_rd == idx);
    endfunction

    // An operand is blocked when its register awaits a write that is not arriving now
    function automatic bit m_stall();
        bit blocked;
        blocked = 1'b0;
        if (m_busy[issue_rs1] && !released(issue_rs1)) blocked = 1'b1;
        if (m_busy[issue_rs2] && !released(issue_rs2)) blocked = 1'b1;
        if (issue_uses_rs3 && m_busy[issue_rs3] && !released(issue_rs3)) blocked = 1'b1;
        if (issue_fp_dest && m_busy[issue_rd] && !released(issue_rd)) blocked = 1'b1;
        return issue_valid && blocked;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (released(idx)) return fp_wdata;
        return m_regs[idx];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    task automatic set_idle();
        wb_fp_en = 0; wb_rd = 0; fp_wdata = 0;
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rs3 = 0;
        issue_uses_rs3 = 0; issue_fp_dest = 0; issue_rd = 0;
    endtask

    // One clock: the model commits exactly what the current inputs imply
    task automatic advance();
        bit acc;
        acc = issue_valid && !m_stall();
        @(posedge clk);
        if (wb_fp_en) begin
            m_regs[wb_rd] = fp_wdata;
            m_busy[wb_rd] = 1'b0;
        end
        if (acc && issue_fp_dest) m_busy[issue_rd] = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        issue_valid = 1; issue_rs1 = 5'd3;
        @(negedge clk);
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1 got %h exp %h", rdata1, 32'h0); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy_vec); end
        advance();
        set_idle();
    endtask

    task automatic test_raw_stall();
        issue_valid = 1; issue_fp_dest = 1; issue_rd = 5'd5;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_first_issue stall got %b exp 0", stall); end
        advance();
        set_idle();
        issue_valid = 1; issue_rs2 = 5'd5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (busy_vec[5] !== 1'b1) begin errors++; $display("FAIL raw_busy5 got %b exp 1", busy_vec[5]); end
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall cyc %0d got %b exp 1", c, stall); end
            advance();
        end
        set_idle();
        issue_valid = 1; issue_rs1 = 5'd5;
        wb_fp_en = 1; wb_rd = 5'd5; fp_wdata = 32'h3F80_0000;
        @(negedge clk);
        if (BYPASS) begin
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wb_cycle_stall got %b exp 0", stall); end
            checks++; if (rdata1 !== 32'h3F80_0000) begin errors++; $display("FAIL wb_cycle_rdata1 got %h exp 3f800000", rdata1); end
        end else begin
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL wb_cycle_stall got %b exp 1", stall); end
        end
        advance();
        wb_fp_en = 0;
        #1;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL after_wb_stall got %b exp 0", stall); end
        checks++; if (rdata1 !== 32'h3F80_0000) begin errors++; $display("FAIL after_wb_rdata1 got %h exp 3f800000", rdata1); end
        checks++; if (busy_vec[5] !== 1'b0) begin errors++; $display("FAIL after_wb_busy5 got %b exp 0", busy_vec[5]); end
        advance();
        set_idle();
    endtask

    task automatic test_set_clear_same();
        // writeback to untracked f7 coincides with an accepted issue targeting f7
        wb_fp_en = 1; wb_rd = 5'd7; fp_wdata = 32'h4000_0000;
        issue_valid = 1; issue_fp_dest = 1; issue_rd = 5'd7;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL setclr_stall got %b exp 0", stall); end
        advance();
        set_idle();
        #1;
        checks++; if (busy_vec[7] !== 1'b1) begin errors++; $display("FAIL setclr_busy7 got %b exp 1", busy_vec[7]); end
        checks++; if (busy_vec !== m_busy) begin errors++; $display("FAIL setclr_busyvec got %h exp %h", busy_vec, m_busy); end
        issue_rs1 = 5'd7;
        #1;
        checks++; if (rdata1 !== 32'h4000_0000) begin errors++; $display("FAIL setclr_rdata got %h exp 40000000", rdata1); end
        wb_fp_en = 1; wb_rd = 5'd7; fp_wdata = 32'h4040_0000;
        advance();
        set_idle();
    endtask

    task automatic test_rs3_mask();
        issue_valid = 1; issue_fp_dest = 1; issue_rd = 5'd9;
        advance();
        set_idle();
        issue_valid = 1; issue_rs1 = 5'd1; issue_rs2 = 5'd2; issue_rs3 = 5'd9; issue_uses_rs3 = 0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rs3_masked stall got %b exp 0", stall); end
        issue_uses_rs3 = 1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rs3_used stall got %b exp 1", stall); end
        // destination on a busy register is a WAW stall
        issue_uses_rs3 = 0; issue_rs3 = 5'd0; issue_fp_dest = 1; issue_rd = 5'd9;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall got %b exp 1", stall); end
        set_idle();
        wb_fp_en = 1; wb_rd = 5'd9; fp_wdata = 32'h1234_5678;
        advance();
        set_idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wb_fp_en       = ($urandom_range(0, 2) == 0);
            wb_rd          = 5'($urandom_range(0, 7));
            fp_wdata       = $urandom;
            issue_valid    = ($urandom_range(0, 3) != 0);
            issue_rs1      = 5'($urandom_range(0, 7));
            issue_rs2      = 5'($urandom_range(0, 7));
            issue_rs3      = 5'($urandom_range(0, 7));
            issue_uses_rs3 = 1'($urandom_range(0, 1));
            issue_fp_dest  = 1'($urandom_range(0, 1));
            issue_rd       = 5'($urandom_range(0, 7));
            @(negedge clk);
            checks++; if (stall !== m_stall()) begin errors++; $display("FAIL rnd_stall cyc %0d got %b exp %b", c, stall, m_stall()); end
            checks++; if (rdata1 !== m_read(issue_rs1)) begin errors++; $display("FAIL rnd_rdata1 cyc %0d got %h exp %h", c, rdata1, m_read(issue_rs1)); end
            checks++; if (rdata2 !== m_read(issue_rs2)) begin errors++; $display("FAIL rnd_rdata2 cyc %0d got %h exp %h", c, rdata2, m_read(issue_rs2)); end
            checks++; if (rdata3 !== m_read(issue_rs3)) begin errors++; $display("FAIL rnd_rdata3 cyc %0d got %h exp %h", c, rdata3, m_read(issue_rs3)); end
            checks++; if (busy_vec !== m_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %h exp %h", c, busy_vec, m_busy); end
            advance();
        end
        set_idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            wb_fp_en = 1; wb_rd = 5'(i); fp_wdata = 32'hA000_0000 + 32'(i);
            advance();
        end
        set_idle();
        issue_valid = 1; issue_fp_dest = 1; issue_rd = 5'd5;
        advance();
        issue_rd = 5'd8;
        advance();
        set_idle();
        issue_rs1 = 5'd1; issue_rs2 = 5'd2; issue_rs3 = 5'd3;
        @(negedge clk);
        checks++; if (busy_vec !== 32'h0000_0120) begin errors++; $display("FAIL pre_rst_busy got %h exp 00000120", busy_vec); end
        checks++; if (rdata2 !== 32'hA000_0002) begin errors++; $display("FAIL pre_rst_rdata2 got %h exp a0000002", rdata2); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL async_rst_busy got %h exp 0", busy_vec); end
        checks++; if ({rdata1, rdata2, rdata3} !== 96'h0) begin errors++; $display("FAIL async_rst_rdata got %h %h %h exp 0", rdata1, rdata2, rdata3); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL async_rst_stall got %b exp 0", stall); end
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        // a write arriving after reset lands normally
        wb_fp_en = 1; wb_rd = 5'd2; fp_wdata = 32'h0BAD_F00D;
        advance();
        set_idle();
        issue_rs2 = 5'd2;
        #1;
        checks++; if (rdata2 !== m_regs[2]) begin errors++; $display("FAIL post_rst_write got %h exp %h", rdata2, m_regs[2]); end
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        model_clear();
        test_reset();
        test_raw_stall();
        test_set_clear_same();
        test_rs3_mask();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_regfile_sb.md
Name: fp_regfile_sb

Overview:
- FP register file plus pending-write scoreboard.
- Sits at the receiving end of the FP writeback path: consumes fp_wdata/wb_fp_en and the destination index from the writeback stage.
- Serves three operand read ports (rs1/rs2/rs3, where rs3 is for fused multiply-add) to decode/issue.
- Stalls issue on RAW/WAW hazards against destinations still in flight.

Parameters:
- XLEN, 32, register data width.
- NREGS, 32, number of FP registers.
- AW, 5, register index width; must equal clog2(NREGS).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- wb_fp_en  input  1  writeback write enable
- wb_rd  input  AW  writeback destination index
- fp_wdata  input  XLEN  writeback data
- issue_valid  input  1  decode presents an FP-using instruction
- issue_rs1  input  AW  source 1 index
- issue_rs2  input  AW  source 2 index
- issue_rs3  input  AW  source 3 index
- issue_uses_rs3  input  1  rs3 is a real operand (FMADD family)
- issue_fp_dest  input  1  instruction will write an FP register
- issue_rd  input  AW  FP destination index
- rdata1  output  XLEN  operand rs1
- rdata2  output  XLEN  operand rs2
- rdata3  output  XLEN  operand rs3
- stall  output  1  issue must hold this cycle
- busy_vec  output  NREGS  scoreboard state, for debug and verification

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is asynchronous and active-high.
  - On reset: all registers are 0, busy_vec is 0. Outputs are then rdata1..3 = 0 and stall = 0.
- Register array:
  - f0 is an ordinary writable register; there is no hardwired zero.
  - Write: on posedge, if wb_fp_en, regs[wb_rd] <= fp_wdata.
- Read ports:
  - Combinational, zero latency.
  - rdataN = regs[issue_rsN]. The bypass case is covered under Optional Feature.
- Hazard terms (all combinational):
  - hazN = busy[issue_rsN] && !clrN.
  - clrN = wb_fp_en && wb_rd == issue_rsN, when bypass is enabled.
  - haz3 is masked when issue_uses_rs3 = 0.
  - hazD = issue_fp_dest && busy[issue_rd] && !clrD. This is a WAW check; only one write may be outstanding per register.
- stall = issue_valid && (haz1 | haz2 | haz3 | hazD).
- Accept = issue_valid && !stall.
- Scoreboard update on posedge:
  - Clear: if wb_fp_en, busy[wb_rd] <= 0.
  - Set: if accept && issue_fp_dest, busy[issue_rd] <= 1.
  - Set and clear on the same index in one cycle: set wins, busy stays 1 (a new writer is in flight).
- Writeback to a non-busy register (e.g. FLW path not tracked): the write still occurs and the busy bit stays 0. This is not an error.
- Reset mid-operation: array and busy_vec are cleared immediately. Any in-flight writeback arriving after reset writes normally.
- Indices are always in range when NREGS = 2^AW; no wrap handling is required.

Optional Feature:
- Macro: FP_RF_BYPASS_EN.
- Defined:
  - Write-through forwarding: if wb_fp_en && wb_rd == issue_rsN, then rdataN = fp_wdata in the same cycle.
  - clrN/clrD terms are active, so a writeback releases a dependent instruction in the same cycle.
- Undefined:
  - rdataN always comes from the array.
  - clr terms are 0, so a dependent instruction stalls until the cycle after writeback (one extra cycle of latency).

Decomposition:
- Package fp_rf_pkg holds:
  - FP_XLEN = 32, FP_NREGS = 32, FP_AW = 5.
  - typedef fp_idx_t (AW bits) and fp_word_t (XLEN bits).
- One sub-module, fp_scoreboard, holds busy_vec, set/clear logic and the hazard/stall equations.
- Array and read muxes stay in the top level.

Test Plan:
1. Reset, then drive issue_rs1 = 3 with no writes -> rdata1 = 0, stall = 0, busy_vec = 0.
2. Issue accepted with issue_fp_dest = 1, issue_rd = 5 -> busy_vec[5] = 1 next cycle. Next instruction with issue_rs2 = 5 -> stall = 1 until the writeback cycle.
3. Writeback wb_rd = 5, fp_wdata = 0x3F800000 while issue_rs1 = 5:
   - With FP_RF_BYPASS_EN: stall = 0 and rdata1 = 0x3F800000 that cycle.
   - Without it: stall = 1 that cycle, stall = 0 and rdata1 = 0x3F800000 next cycle.
4. Same cycle: writeback clears f7 while an accepted issue sets rd = 7 -> busy_vec[7] = 1 afterwards.
5. FMADD with issue_uses_rs3 = 0 and busy f9 = issue_rs3 -> stall = 0. Same with issue_uses_rs3 = 1 -> stall = 1.
6. Assert rst asynchronously between clock edges with busy_vec = 0x00000120 and regs non-zero -> busy_vec = 0 and all rdata = 0 immediately, before the next edge.
